uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between two byte-stream requesters: req0 is the keystroke echo path
//  and req1 is the RPN result printer. Grants are round-robin and packet-locked: once a requester

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one uart_tx between the echo path (req0)
// and the result printer (req1); issues the single-cycle tx_start launch pulse.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 125000,
  parameter int unsigned ACK_WAIT       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned ACK_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ACK_W-1:0] ACK_MAX = ACK_W'(ACK_WAIT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, POST} state_t;

  state_t           state, state_nxt;
  logic [1:0]       grant_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_start_nxt, timeout_err_nxt;
  logic             last_q, last_q_nxt;
  logic             rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [ACK_W-1:0] ack_cnt, ack_cnt_nxt;
  logic             hs;
  logic [7:0]       own_data;
  logic             own_last;

  // Only the owner sees ready, and only while uart_tx can take a byte
  assign req0_ready = (state == ISSUE) && grant[0] && !tx_busy;
  assign req1_ready = (state == ISSUE) && grant[1] && !tx_busy;
  assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign own_data   = grant[1] ? req1_data : req0_data;
  assign own_last   = grant[1] ? req1_last : req0_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 2'b00;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      last_q      <= 1'b0;
      rr_ptr      <= 1'b0;
      idle_cnt    <= '0;
      ack_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      tx_data     <= tx_data_nxt;
      tx_start    <= tx_start_nxt;
      timeout_err <= timeout_err_nxt;
      last_q      <= last_q_nxt;
      rr_ptr      <= rr_ptr_nxt;
      idle_cnt    <= idle_cnt_nxt;
      ack_cnt     <= ack_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    tx_data_nxt     = tx_data;
    tx_start_nxt    = 1'b0;
    timeout_err_nxt = 1'b0;
    last_q_nxt      = last_q;
    rr_ptr_nxt      = rr_ptr;
    idle_cnt_nxt    = idle_cnt;
    ack_cnt_nxt     = ack_cnt;
    case (state)
      IDLE: begin
        grant_nxt    = 2'b00;
        idle_cnt_nxt = '0;
        if (req0_valid && req1_valid) grant_nxt = rr_ptr ? 2'b10 : 2'b01;
        else if (req0_valid)          grant_nxt = 2'b01;
        else if (req1_valid)          grant_nxt = 2'b10;
        if (req0_valid || req1_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (hs) begin
          tx_data_nxt  = own_data;
          last_q_nxt   = own_last;
          tx_start_nxt = 1'b1;
          ack_cnt_nxt  = '0;
          state_nxt    = WAIT_ACK;
        end else if (idle_cnt == CNT_MAX) begin
          // Owner stalled too long: drop the lock and favour the other side
          timeout_err_nxt = 1'b1;
          grant_nxt       = 2'b00;
          rr_ptr_nxt      = ~grant[1];
          state_nxt       = IDLE;
        end else begin
          idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (tx_busy)                 state_nxt = WAIT_DONE;
        else if (ack_cnt == ACK_MAX) state_nxt = POST;
        else                         ack_cnt_nxt = ack_cnt + ACK_W'(1);
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = POST;
      end
      POST: begin
        if (last_q) begin
          grant_nxt  = 2'b00;
          rr_ptr_nxt = ~grant[1];
          state_nxt  = IDLE;
        end else begin
          idle_cnt_nxt = '0;
          state_nxt    = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded directed bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] tx_data;
  logic       tx_start, tx_busy, timeout_err;
  logic [1:0] grant;

  typedef struct packed { logic [1:0] grant; logic [7:0] data; } exp_t;
  exp_t exp_q[$];
  int   ts_cyc[$];
  int   cmp_cnt = 0;
  int   mism_cnt = 0;
  int   cyc = 0;
  int   ts_count = 0;
  int   busy_len = 0;
  int   busy_cnt = 0;
  logic prev_start = 1'b0;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16), .ACK_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy for busy_len cycles after each launch, unaffected by arbiter reset
  always @(posedge clk) begin
    if (busy_cnt > 0)                   busy_cnt <= busy_cnt - 1;
    else if (tx_start && busy_len > 0)  busy_cnt <= busy_len;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor: every launch must match the next expected byte and owner
  always @(negedge clk) begin
    if (tx_start) begin
      exp_t e;
      ts_count++;
      ts_cyc.push_back(cyc);
      cmp_cnt++;
      if (prev_start) begin
        mism_cnt++;
        $display("FAIL tx_start_b2b: got two consecutive pulses, required single-cycle pulse");
      end
      cmp_cnt++;
      if (exp_q.size() == 0) begin
        mism_cnt++;
        $display("FAIL tx_unexpected: got data=%h grant=%b, required no launch", tx_data, grant);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e.data || grant !== e.grant) begin
          mism_cnt++;
          $display("FAIL tx_byte: got data=%h grant=%b, required data=%h grant=%b",
                   tx_data, grant, e.data, e.grant);
        end
      end
    end
    prev_start = tx_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      mism_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.grant = g;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Present one byte and hold it until accepted; valid drops after a last byte
  task automatic send(input int idx, input logic [7:0] d, input logic l);
    logic done = 1'b0;
    if (idx == 0) begin req0_data = d; req0_last = l; req0_valid = 1'b1; end
    else          begin req1_data = d; req1_last = l; req1_valid = 1'b1; end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if ((idx == 0 && req0_ready) || (idx == 1 && req1_ready)) done = 1'b1;
    end
    check($sformatf("handshake_req%0d_%h", idx, d), 32'(done), 32'd1);
    @(posedge clk); #1;
    if (l) begin
      if (idx == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant == 2'b00 && !tx_busy) break;
    end
  endtask

  task automatic wait_grant(input logic [1:0] g);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant == g) break;
    end
  endtask

  task automatic do_reset();
    wait_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first_to, pulses, base, t5_base;
    logic [1:0] g_at;
    rst_n = 1'b0;
    req0_data = 8'h00; req0_valid = 1'b0; req0_last = 1'b0;
    req1_data = 8'h00; req1_valid = 1'b0; req1_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    rst_n = 1'b1;

    // 1: single echo byte, busy 10 cycles, latency check
    busy_len = 10;
    @(posedge clk); #1;
    push_exp(2'b01, 8'h41);
    req0_data = 8'h41; req0_last = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    check("t1_grant_pre", 32'(grant), 32'd0);
    @(negedge clk);
    check("t1_grant", 32'(grant), 32'b01);
    check("t1_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_tx_start", 32'(tx_start), 32'd1);
    check("t1_tx_data", 32'(tx_data), 32'h41);
    wait_idle();
    check("t1_release", 32'(grant), 32'd0);

    // 2: simultaneous requests after reset, req0 wins then req1
    busy_len = 3;
    do_reset();
    push_exp(2'b01, 8'hA0);
    push_exp(2'b10, 8'hB0);
    fork
      send(0, 8'hA0, 1'b1);
      send(1, 8'hB0, 1'b1);
    join
    wait_idle();
    check("t2_release", 32'(grant), 32'd0);

    // 3: req1 packet "12\r\n" locked against a waiting req0
    push_exp(2'b10, 8'h31); push_exp(2'b10, 8'h32);
    push_exp(2'b10, 8'h0D); push_exp(2'b10, 8'h0A);
    push_exp(2'b01, 8'h55);
    fork
      begin
        send(1, 8'h31, 1'b0); send(1, 8'h32, 1'b0);
        send(1, 8'h0D, 1'b0); send(1, 8'h0A, 1'b1);
      end
      begin
        wait_grant(2'b10);
        send(0, 8'h55, 1'b1);
      end
    join
    wait_idle();
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: owner stalls mid-packet with busy tied low; timeout hands over to req0
    busy_len = 0;
    push_exp(2'b10, 8'h31);
    push_exp(2'b01, 8'h77);
    first_to = 0; pulses = 0; g_at = 2'b11;
    fork
      begin
        send(1, 8'h31, 1'b0);
        req1_valid = 1'b0;
        for (int n = 1; n <= 30; n++) begin
          @(negedge clk);
          if (timeout_err) begin
            pulses++;
            if (first_to == 0) begin first_to = n; g_at = grant; end
          end
        end
      end
      begin
        wait_grant(2'b10);
        send(0, 8'h77, 1'b1);
      end
    join
    check("t4_timeout_cycle", 32'(first_to), 32'd22);
    check("t4_timeout_pulses", 32'(pulses), 32'd1);
    check("t4_grant_at_timeout", 32'(g_at), 32'd0);
    wait_idle();

    // 5: busy never rises, each byte advances after ACK_WAIT cycles
    t5_base = ts_cyc.size();
    push_exp(2'b01, 8'hE1);
    push_exp(2'b01, 8'hE2);
    send(0, 8'hE1, 1'b0);
    send(0, 8'hE2, 1'b1);
    wait_idle();
    if (ts_cyc.size() >= t5_base + 2)
      check("t5_start_spacing", 32'(ts_cyc[t5_base+1] - ts_cyc[t5_base]), 32'd6);
    else
      check("t5_start_count", 32'(ts_cyc.size() - t5_base), 32'd2);

    // 6: reset while uart_tx is busy with a byte
    busy_len = 10;
    push_exp(2'b01, 8'hC3);
    send(0, 8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_busy_before_rst", 32'(tx_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_tx_start", 32'(tx_start), 32'd0);
    check("t6_rst_tx_data", 32'(tx_data), 32'h00);
    check("t6_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    base = ts_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_spurious_start", 32'(ts_count - base), 32'd0);
    check("t6_grant_idle", 32'(grant), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
    $finish;
  end

endmodule
